biquad8_coeff_loader: RTL and testbench

BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

---
 rtl/biquad8_coeff_loader_if.sv | 21 ++
 rtl/biquad8_coeff_loader.sv | 112 +++++++++++
 tb/tb_biquad8_coeff_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad8_coeff_loader_if.sv
// biquad8_coeff_loader_if: WISHBONE bus between the coefficient loader and one biquad8 target
// master: drives wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o[6:0], wbm_dat_o[31:0], wbm_sel_o[3:0]
// slave : drives wbm_ack_i, wbm_err_i
interface biquad8_coeff_loader_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [6:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_err_i
    );
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: queues {adr,dat} coefficient commands and writes them to a biquad8 over WISHBONE, then an update write
// clock/reset : wb_clk_i (rising edge), wb_rst_ni (async assert, active-low)
// command     : cmd_valid_i/cmd_ready_o push handshake, cmd_adr_i[4:0], cmd_dat_i[17:0]
// control     : go_i start, busy_o, done_o (pulse), err_o (sticky), err_clr_i, fifo_cnt_o occupancy
// bus         : wbm (biquad8_coeff_loader_if.master)
// option      : BIQUAD8_LOADER_TIMEOUT_EN adds an ack timeout of TIMEOUT cycles
module biquad8_coeff_loader #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [4:0]                  cmd_adr_i,
    input  logic [17:0]                 cmd_dat_i,
    input  logic                        go_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    input  logic                        err_clr_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    biquad8_coeff_loader_if.master      wbm
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, WRITE, GAP, UPDATE, DONE} state_t;
    state_t        state;
    logic [22:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          cyc, stb, we, done, err;
    logic [3:0]    sel;
    logic [6:0]    adr;
    logic [31:0]   dat;
    logic          push, on_bus, timeout, abort, has_cmd;
    logic [22:0]   head;

    // ready is forced low while reset is held so nothing is accepted into a FIFO being cleared
    assign cmd_ready_o = wb_rst_ni && !cnt[AW] && state == IDLE;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign on_bus      = state == WRITE || state == UPDATE;
    assign abort       = on_bus && (wbm.wbm_err_i || timeout);
    assign has_cmd     = cnt != '0;
    assign head        = mem[rp];

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    logic [15:0] tcnt;
    // START/GAP always precede WRITE/UPDATE, so the counter is zero on entry
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) tcnt <= '0;
        else tcnt <= (on_bus && !wbm.wbm_ack_i) ? tcnt + 16'd1 : '0;
    assign timeout = !wbm.wbm_ack_i && tcnt == 16'(TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i)
        if (push) mem[wp] <= {cmd_adr_i, cmd_dat_i};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            {cyc, stb, we, sel, adr, dat} <= '0;
            {done, err} <= '0;
            {wp, rp, cnt} <= '0;
        end else begin
            done <= 1'b0;
            err  <= abort || (err && !err_clr_i);
            if (push) begin
                wp  <= wp + 1'b1;
                cnt <= cnt + 1'b1;
            end
            case (state)
                IDLE: if (go_i) state <= START;
                START, GAP: begin
                    state <= has_cmd ? WRITE : UPDATE;
                    {cyc, stb, we, sel} <= 7'h7F;
                    adr <= has_cmd ? {head[22:18], 2'b00} : 7'h00;
                    dat <= has_cmd ? {14'b0, head[17:0]} : 32'h1;
                end
                WRITE, UPDATE: begin
                    if (abort || wbm.wbm_ack_i) {cyc, stb, we, sel, adr, dat} <= '0;
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        rp    <= wp;
                    end else if (wbm.wbm_ack_i) begin
                        state <= (state == WRITE) ? GAP : DONE;
                        done  <= state == UPDATE;
                        if (state == WRITE) begin
                            rp  <= rp + 1'b1;
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o        = state != IDLE;
    assign done_o        = done;
    assign err_o         = err;
    assign fifo_cnt_o    = cnt;
    assign wbm.wbm_cyc_o = cyc;
    assign wbm.wbm_stb_o = stb;
    assign wbm.wbm_we_o  = we;
    assign wbm.wbm_sel_o = sel;
    assign wbm.wbm_adr_o = adr;
    assign wbm.wbm_dat_o = dat;
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb_biquad8_coeff_loader: self-checking bench for biquad8_coeff_loader (table vectors, random runs, corner sequences)
module tb_biquad8_coeff_loader;
    logic        clk = 0, rst_n = 1;
    logic        cmd_valid = 0, cmd_ready, go = 0, busy, done, err, err_clr = 0;
    logic [4:0]  cmd_adr = 0;
    logic [17:0] cmd_dat = 0;
    logic [4:0]  fifo_cnt;

    always #5 clk = ~clk;

    biquad8_coeff_loader_if bus();

    biquad8_coeff_loader #(.FIFO_DEPTH(16), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .go_i(go), .busy_o(busy), .done_o(done), .err_o(err), .err_clr_i(err_clr),
        .fifo_cnt_o(fifo_cnt), .wbm(bus)
    );

    int checks = 0, errors = 0;
    int ack_lat = 1, err_at = 0, wr_idx = 0, done_cnt = 0, idle_cnt = 0, model_cnt = 0;
    bit no_ack = 0;
    logic [45:0] log_q[$], exp_q[$];

    typedef struct {int n; int k; int exp_busy; int exp_idle;} vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {cyc,stb,we,sel,adr,dat} as seen on the bus at the acked cycle
    function automatic logic [45:0] ent(input logic [6:0] a, input logic [31:0] d);
        return {3'b111, 4'hF, a, d};
    endfunction

    // slave: acks (or errors) after ack_lat cycles of cyc, logs every acked transfer
    initial begin
        int wcnt;
        wcnt = 0;
        bus.wbm_ack_i = 0;
        bus.wbm_err_i = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.wbm_ack_i = 0;
            bus.wbm_err_i = 0;
            if (bus.wbm_cyc_o) begin
                wcnt++;
                if (wcnt == 1) wr_idx++;
                if (!no_ack && wcnt == ack_lat) begin
                    if (wr_idx == err_at) bus.wbm_err_i = 1;
                    else begin
                        bus.wbm_ack_i = 1;
                        log_q.push_back({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                                         bus.wbm_adr_o, bus.wbm_dat_o});
                    end
                end
            end else wcnt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (busy && !bus.wbm_cyc_o) idle_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic prep();
        log_q.delete();
        exp_q.delete();
        wr_idx = 0;
        done_cnt = 0;
        idle_cnt = 0;
        model_cnt = 0;
    endtask

    task automatic push(input logic [4:0] a, input logic [17:0] d, input bit with_go = 0);
        @(negedge clk);
        cmd_valid = 1; cmd_adr = a; cmd_dat = d; go = with_go;
        if (model_cnt < 16) begin
            exp_q.push_back(ent({a, 2'b00}, {14'b0, d}));
            model_cnt++;
        end
        @(negedge clk);
        cmd_valid = 0; go = 0;
    endtask

    task automatic run(input string name, input int exp_busy, input int exp_idle, input int exp_done,
                       input bit go_done = 0);
        int bc = 0;
        if (!go_done) begin
            @(negedge clk); go = 1;
            @(negedge clk); go = 0;
        end
        for (int i = 0; i < 3000 && busy; i++) begin
            bc++;
            @(negedge clk);
        end
        chk({name, "_ended"}, busy, 0);
        chk({name, "_busy_cycles"}, bc, exp_busy);
        chk({name, "_idle_busy"}, idle_cnt, exp_idle);
        chk({name, "_done"}, done_cnt, exp_done);
        chk({name, "_fifo_cnt"}, fifo_cnt, 0);
        chk({name, "_bus_idle"}, {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                                  bus.wbm_adr_o, bus.wbm_dat_o}, 0);
        if (exp_done != 0) exp_q.push_back(ent(7'h00, 32'h1));
        chk({name, "_nwrites"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_write%0d", name, i), log_q[i], exp_q[i]);
        model_cnt = 0;
    endtask

    task automatic hard_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk);
        @(negedge clk); rst_n = 1;
        model_cnt = 0;
    endtask

    initial begin
        int n, k, hi;
        vecs[0] = '{0, 1, 3, 2};
        vecs[1] = '{0, 3, 5, 2};
        vecs[2] = '{1, 1, 5, 3};
        vecs[3] = '{2, 2, 10, 4};
        vecs[4] = '{3, 1, 9, 5};
        vecs[5] = '{3, 3, 17, 5};
        vecs[6] = '{1, 4, 11, 3};

        #1 rst_n = 0;
        #2;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_flags", {done, err}, 0);
        chk("rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                        bus.wbm_adr_o, bus.wbm_dat_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 chk("rst_release_ready", cmd_ready, 1);

        foreach (vecs[v]) begin
            prep();
            ack_lat = vecs[v].k;
            for (int j = 0; j < vecs[v].n; j++) push(5'($urandom), 18'($urandom));
            chk($sformatf("vec%0d_cnt", v), fifo_cnt, vecs[v].n);
            run($sformatf("vec%0d", v), vecs[v].exp_busy, vecs[v].exp_idle, 1);
        end

        for (int r = 0; r < 6; r++) begin
            prep();
            n = $urandom_range(0, 16);
            k = $urandom_range(1, 4);
            ack_lat = k;
            for (int j = 0; j < n; j++) push(5'($urandom), 18'($urandom));
            chk($sformatf("rnd%0d_cnt", r), fifo_cnt, n);
            run($sformatf("rnd%0d", r), 1 + n * (k + 1) + k + 1, n + 2, 1);
        end

        prep();
        ack_lat = 3;
        push(5'd1, 18'h00123);
        push(5'd2, 18'h3FFFF);
        push(5'd4, 18'h00001);
        chk("ex_cnt", fifo_cnt, 3);
        run("ex", 17, 5, 1);
        if (log_q.size() == 4) begin
            chk("ex_adr0", log_q[0][38:32], 7'h04);
            chk("ex_adr2", log_q[2][38:32], 7'h10);
            chk("ex_dat1", log_q[1][31:0], 32'h0003FFFF);
            chk("ex_upd", log_q[3][38:0], {7'h00, 32'h1});
        end

        prep();
        ack_lat = 2;
        push(5'd7, 18'h155, 1);
        run("push_go", 7, 3, 1, 1);

        prep();
        ack_lat = 1;
        for (int j = 0; j < 16; j++) push(5'($urandom), 18'($urandom));
        chk("full_ready", cmd_ready, 0);
        push(5'h1F, 18'h3FFFF);
        chk("full_cnt", fifo_cnt, 16);
        run("full", 35, 18, 1);

        prep();
        ack_lat = 2;
        err_at = 2;
        for (int j = 0; j < 3; j++) push(5'($urandom), 18'($urandom));
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        run("err", 6, 2, 0);
        chk("err_set", err, 1);
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        chk("err_cleared", err, 0);

        prep();
        err_at = 1;
        err_clr = 1;
        push(5'd3, 18'h1234);
        exp_q.delete();
        run("err_pri", 3, 1, 0);
        chk("err_pri_set", err, 1);
        @(negedge clk);
        chk("err_pri_clr", err, 0);
        err_clr = 0;
        err_at = 0;

        prep();
        no_ack = 1;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        hi = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (bus.wbm_cyc_o) hi++;
            else if (hi > 0) break;
        end
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
        chk("timeout_cyc", hi, 8);
        chk("timeout_err", err, 1);
`else
        chk("no_timeout_cyc", hi, 1100);
        chk("no_timeout_err", err, 0);
`endif
        hard_reset();
        no_ack = 0;
        chk("hard_reset_err", err, 0);

        prep();
        no_ack = 1;
        push(5'd3, 18'h2AAAA);
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        for (int i = 0; i < 20 && !bus.wbm_cyc_o; i++) @(negedge clk);
        chk("midrst_pre_cyc", bus.wbm_cyc_o, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", fifo_cnt, 0);
        @(negedge clk); rst_n = 1;
        no_ack = 0;
        #1;
        chk("midrst_post_cnt", fifo_cnt, 0);
        chk("midrst_post_idle", {busy, cmd_ready}, 2'b01);
        prep();
        ack_lat = 1;
        run("post_rst", 3, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
